// File: rtl/alu_mul_seq.sv
// 32x32 unsigned shift-add multiplier using the shared ALU (ADD) via req/gnt; optional MUL_ZERO_BYPASS_EN.
// Latency: 32 granted RUN cycles + 1 DONE cycle after start (bypass: done next cycle).
// Backpressure: alu_gnt=0 stalls the step; start is ignored while ready=0.
module alu_mul_seq #(
  parameter int XLEN  = 32,
  parameter int STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] prod_hi,
  output logic [XLEN-1:0] prod_lo,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_c
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [5:0]      cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = op_a;
          lo_d    = op_b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef MUL_ZERO_BYPASS_EN
          if (op_a == '0 || op_b == '0) begin
            lo_d    = '0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        // Every step, add or not, consumes one granted ALU cycle.
        if (alu_gnt) begin
          if (lo_q[0]) begin
            {hi_d, lo_d} = {alu_c, alu_result, lo_q[XLEN-1:1]};
          end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign alu_req  = (state_q == S_RUN);
  assign alu_a    = hi_q;
  assign alu_b    = mcand_q;
  assign alu_ctrl = ALU_ADD;
  assign prod_hi  = hi_q;
  assign prod_lo  = lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: vector table plus hand sequences, products checked from a scoreboard queue.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        ready, done, alu_req, alu_c;
  logic [31:0] prod_hi, prod_lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_gnt = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  // Shared ALU stand-in: 32-bit add with carry-out.
  assign {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

  alu_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_c(alu_c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pops the oldest expected product.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("product", {prod_hi, prod_lo}, sb_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          mode;      // 0: gnt always 1, 1: gnt 0 on odd RUN cycles
    int          exp_done;
    int          exp_req;
  } vec_t;

`ifdef MUL_ZERO_BYPASS_EN
  localparam int ZERO_DONE = 1;
  localparam int ZERO_REQ  = 0;
`else
  localparam int ZERO_DONE = 33;
  localparam int ZERO_REQ  = 32;
`endif

  // Runs one multiply from an idle DUT; cycle 0 is the accepting cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode,
                        input int exp_done, input int exp_req, input int p1, input int p2,
                        input string name);
    int k;
    int req_cnt;
    bit seen;
    logic [63:0] exp_prod;
    exp_prod = {32'd0, a} * {32'd0, b};
    @(negedge clk);
    check({name, "_ready_idle"}, {63'd0, ready}, 64'd1);
    op_a = a;
    op_b = b;
    start = 1'b1;
    sb_q.push_back(exp_prod);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    req_cnt = 0;
    seen = 1'b0;
    while (!seen && k <= 300) begin
      alu_gnt = (mode == 0) ? 1'b1 : (k % 2 == 0);
      if (k == p1 || k == p2) begin
        check({name, "_ready_busy"}, {63'd0, ready}, 64'd0);
        start = 1'b1;
        op_a = ~a;
      end else begin
        start = 1'b0;
      end
      if (alu_req) req_cnt++;
      if (done) begin
        seen = 1'b1;
        check({name, "_done_cycle"}, 64'(k), 64'(exp_done));
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen) check({name, "_done_timeout"}, 64'(k), 64'(exp_done));
    if (start) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    check({name, "_req_cycles"}, 64'(req_cnt), 64'(exp_req));
    @(negedge clk);
    check({name, "_ready_after"}, {63'd0, ready}, 64'd1);
    check({name, "_prod_hold"}, {prod_hi, prod_lo}, exp_prod);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'd3,         32'd5,         0, 33,        32};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  0, 33,        32};
    vecs[2] = '{32'h12345678,  32'h9ABCDEF0,  1, 65,        64};
    vecs[3] = '{32'd0,         32'd7,         0, ZERO_DONE, ZERO_REQ};
    vecs[4] = '{32'h80000000,  32'h80000001,  0, 33,        32};
    vecs[5] = '{$urandom | 32'h1, $urandom | 32'h1, 1, 65,  64};
    vecs[6] = '{32'hFFFFFFFF,  32'd1,         0, 33,        32};

    #12;
    check("rst_ready",    {63'd0, ready},   64'd1);
    check("rst_done",     {63'd0, done},    64'd0);
    check("rst_req",      {63'd0, alu_req}, 64'd0);
    check("rst_prod",     {prod_hi, prod_lo}, 64'd0);
    check("rst_alu_ab",   {alu_a, alu_b},   64'd0);
    check("rst_alu_ctrl", {61'd0, alu_ctrl}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp_done, vecs[i].exp_req,
             -1, -1, $sformatf("vec%0d", i));
    end

    // Starts while busy (mid-RUN and in the DONE cycle) must be ignored.
    run_op(32'hDEADBEEF, 32'h00C0FFEE, 0, 33, 32, 5, 33, "ignore_start");

    // Grant outside RUN does nothing.
    alu_gnt = 1'b1;
    repeat (3) @(negedge clk);
    check("gnt_idle_ready", {63'd0, ready}, 64'd1);
    check("gnt_idle_prod", {prod_hi, prod_lo}, 64'h00000000DEADBEEF * 64'h0000000000C0FFEE);

    // Reset in the middle of RUN discards the partial product.
    @(negedge clk);
    op_a = 32'hA5A5A5A5;
    op_b = 32'hFFFF0001;
    start = 1'b1;
    sb_q.push_back(64'h0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrun_req", {63'd0, alu_req}, 64'd1);
    rst = 1'b0;
    #1;
    check("abort_ready", {63'd0, ready},   64'd1);
    check("abort_req",   {63'd0, alu_req}, 64'd0);
    check("abort_done",  {63'd0, done},    64'd0);
    check("abort_prod",  {prod_hi, prod_lo}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_op(32'h0001_0003, 32'h0002_0005, 0, 33, 32, -1, -1, "after_abort");

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
